// File: rtl/i2s_rx_channel.sv
// I2S receive deserializer: frames words on WS transitions, assembles up to
// 32-bit words MSB- or LSB-first and queues them in a 2-entry output buffer.
module i2s_rx_channel (
  input  logic        clk_i,
  input  logic        rstn_i,
  input  logic        cfg_en_i,
  input  logic        cfg_lsb_first_i,
  input  logic [4:0]  cfg_word_size_i,
  input  logic [2:0]  cfg_word_num_i,
  input  logic        ws_i,
  input  logic        sd_i,
  output logic [31:0] data_o,
  output logic        ch_o,
  output logic        data_valid_o,
  input  logic        data_ready_i,
  output logic        overflow_o
);

  typedef enum logic [1:0] {IDLE, SYNC, RX, WAIT} state_e;

  state_e      state_q, state_d;
  logic        ws_prev_q;
  logic        ch_q, ch_d;
  logic [4:0]  bit_cnt_q, bit_cnt_d;
  logic [2:0]  word_cnt_q, word_cnt_d;
  logic [31:0] word_q, word_d;

  logic [32:0] ent0_q, ent0_d;
  logic [32:0] ent1_q, ent1_d;
  logic [1:0]  cnt_q, cnt_d;
  logic        ovf_q, ovf_d;

  logic        ws_edge;
  logic        last_bit;
  logic        push;
  logic        pop;
  logic        flush;
  logic [31:0] word_base;
  logic [31:0] word_smp;

  assign ws_edge  = ws_i ^ ws_prev_q;
  assign last_bit = (bit_cnt_q == cfg_word_size_i);

  // A fresh word starts from zero so unused upper bits stay cleared.
  always_comb begin
    word_base = (bit_cnt_q == 5'd0) ? 32'd0 : word_q;
    word_smp  = word_base;
    if (cfg_lsb_first_i) begin
      word_smp[bit_cnt_q] = sd_i;
    end else begin
      word_smp = {word_base[30:0], sd_i};
    end
  end

  always_comb begin
    state_d    = state_q;
    ch_d       = ch_q;
    bit_cnt_d  = bit_cnt_q;
    word_cnt_d = word_cnt_q;
    word_d     = word_q;
    push       = 1'b0;
    case (state_q)
      IDLE: begin
        bit_cnt_d  = 5'd0;
        word_cnt_d = 3'd0;
        word_d     = 32'd0;
        if (cfg_en_i) state_d = SYNC;
      end
      SYNC, WAIT: begin
        if (ws_edge) begin
          ch_d       = ws_i;
          bit_cnt_d  = 5'd0;
          word_cnt_d = 3'd0;
          state_d    = RX;
        end
      end
      RX: begin
        word_d = word_smp;
        if (last_bit) begin
          push      = 1'b1;
          bit_cnt_d = 5'd0;
          if (word_cnt_q == cfg_word_num_i) begin
            state_d = WAIT;
          end else begin
            word_cnt_d = word_cnt_q + 3'd1;
          end
        end else begin
          bit_cnt_d = bit_cnt_q + 5'd1;
        end
        // The edge-cycle sample closes the old word; anything partial is dropped.
        if (ws_edge) begin
          ch_d       = ws_i;
          bit_cnt_d  = 5'd0;
          word_cnt_d = 3'd0;
          state_d    = RX;
        end
      end
      default: state_d = IDLE;
    endcase
    if (!cfg_en_i) begin
      state_d = IDLE;
      push    = 1'b0;
    end
  end

  assign flush = !cfg_en_i || (state_q == IDLE);
  assign pop   = (cnt_q != 2'd0) && data_ready_i;

  // Shift-register FIFO: entry 0 is always the head.
  always_comb begin
    ent0_d = ent0_q;
    ent1_d = ent1_q;
    cnt_d  = cnt_q;
    ovf_d  = ovf_q;
    if (flush) begin
      ent0_d = 33'd0;
      ent1_d = 33'd0;
      cnt_d  = 2'd0;
      ovf_d  = 1'b0;
    end else begin
      if (pop) begin
        ent0_d = ent1_q;
        cnt_d  = cnt_q - 2'd1;
      end
      if (push) begin
        if (cnt_d == 2'd2) begin
          ovf_d = 1'b1;
        end else begin
          if (cnt_d == 2'd0) ent0_d = {word_smp, ch_q};
          else               ent1_d = {word_smp, ch_q};
          cnt_d = cnt_d + 2'd1;
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q    <= IDLE;
      ws_prev_q  <= 1'b0;
      ch_q       <= 1'b0;
      bit_cnt_q  <= 5'd0;
      word_cnt_q <= 3'd0;
      word_q     <= 32'd0;
      ent0_q     <= 33'd0;
      ent1_q     <= 33'd0;
      cnt_q      <= 2'd0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      ws_prev_q  <= ws_i;
      ch_q       <= ch_d;
      bit_cnt_q  <= bit_cnt_d;
      word_cnt_q <= word_cnt_d;
      word_q     <= word_d;
      ent0_q     <= ent0_d;
      ent1_q     <= ent1_d;
      cnt_q      <= cnt_d;
      ovf_q      <= ovf_d;
    end
  end

  assign data_o       = ent0_q[32:1];
  assign ch_o         = ent0_q[0];
  assign data_valid_o = (cnt_q != 2'd0);
  assign overflow_o   = ovf_q;

endmodule

// File: tb/tb_i2s_rx_channel.sv
// Directed bench for i2s_rx_channel: streams hand-built I2S frames and checks
// the received words, their channel and push cycle against expected tables.
module tb_i2s_rx_channel;

  logic        clk;
  logic        rstn;
  logic        cfg_en;
  logic        cfg_lsb_first;
  logic [4:0]  cfg_word_size;
  logic [2:0]  cfg_word_num;
  logic        ws;
  logic        sd;
  logic [31:0] data;
  logic        ch;
  logic        data_valid;
  logic        data_ready;
  logic        overflow;

  int n_checks = 0;
  int n_fail   = 0;

  logic        ws_q[$];
  logic        sd_q[$];
  logic [32:0] obs_w[$];
  int          obs_c[$];
  logic [32:0] exp_w[$];
  int          exp_c[$];

  i2s_rx_channel dut (
    .clk_i           (clk),
    .rstn_i          (rstn),
    .cfg_en_i        (cfg_en),
    .cfg_lsb_first_i (cfg_lsb_first),
    .cfg_word_size_i (cfg_word_size),
    .cfg_word_num_i  (cfg_word_num),
    .ws_i            (ws),
    .sd_i            (sd),
    .data_o          (data),
    .ch_o            (ch),
    .data_valid_o    (data_valid),
    .data_ready_i    (data_ready),
    .overflow_o      (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic cycle(input logic w, input logic s);
    @(negedge clk);
    ws = w;
    sd = s;
    @(posedge clk);
    #1;
  endtask

  // Stream builders: sd_q carries one extra leading bit for the I2S one-cycle delay.
  task automatic new_stream(input logic lvl, input int n, input bit noisy);
    ws_q.delete();
    sd_q.delete();
    for (int i = 0; i < n; i++) ws_q.push_back(lvl);
    for (int i = 0; i <= n; i++) sd_q.push_back(noisy ? i[0] : 1'b0);
  endtask

  task automatic add_half(input logic lvl, input logic [31:0] w0, input logic [31:0] w1,
                          input int nw, input int nbits, input int halflen, input bit lsb);
    logic [31:0] v;
    int idx;
    int b;
    for (int j = 0; j < halflen; j++) begin
      ws_q.push_back(lvl);
      idx = j / nbits;
      b   = j % nbits;
      v   = (idx == 0) ? w0 : w1;
      if (idx < nw) sd_q.push_back(lsb ? v[b] : v[nbits-1-b]);
      else          sd_q.push_back(1'b0);
    end
  endtask

  task automatic add_trail(input logic lvl);
    for (int j = 0; j < 3; j++) begin
      ws_q.push_back(lvl);
      sd_q.push_back(1'b0);
    end
  endtask

  task automatic play(input int n);
    for (int i = 0; i < n; i++) begin
      cycle(ws_q[i], sd_q[i]);
      if (data_valid && data_ready) begin
        obs_w.push_back({data, ch});
        obs_c.push_back(i);
      end
    end
  endtask

  task automatic expect_word(input int c, input logic [31:0] d, input logic chn);
    exp_w.push_back({d, chn});
    exp_c.push_back(c);
  endtask

  task automatic compare_words(input string name);
    chk({name, "_count"}, 64'(obs_w.size()), 64'(exp_w.size()));
    for (int i = 0; i < exp_w.size() && i < obs_w.size(); i++) begin
      chk($sformatf("%s_w%0d", name, i), 64'(obs_w[i]), 64'(exp_w[i]));
      chk($sformatf("%s_c%0d", name, i), 64'(obs_c[i]), 64'(exp_c[i]));
    end
  endtask

  task automatic start_scn(input logic lvl, input logic [4:0] wsz, input logic [2:0] wn,
                           input logic lsb, input logic rdy);
    cfg_en = 1'b0;
    cycle(lvl, 1'b0);
    cycle(lvl, 1'b0);
    cfg_word_size = wsz;
    cfg_word_num  = wn;
    cfg_lsb_first = lsb;
    data_ready    = rdy;
    cfg_en        = 1'b1;
    obs_w.delete();
    obs_c.delete();
    exp_w.delete();
    exp_c.delete();
  endtask

  initial begin
    rstn          = 1'b0;
    cfg_en        = 1'b0;
    cfg_lsb_first = 1'b0;
    cfg_word_size = 5'd15;
    cfg_word_num  = 3'd0;
    ws            = 1'b0;
    sd            = 1'b0;
    data_ready    = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rstn = 1'b1;
    #1;
    chk("rst_data", 64'(data), 64'd0);
    chk("rst_ch", 64'(ch), 64'd0);
    chk("rst_valid", 64'(data_valid), 64'd0);
    chk("rst_ovf", 64'(overflow), 64'd0);

    // Basic MSB-first: pushes land on the right edge and the trailing edge.
    start_scn(1'b1, 5'd15, 3'd0, 1'b0, 1'b1);
    new_stream(1'b1, 4, 1'b0);
    add_half(1'b0, 32'hA5C3, 32'h0, 1, 16, 16, 1'b0);
    add_half(1'b1, 32'h1234, 32'h0, 1, 16, 16, 1'b0);
    add_trail(1'b0);
    expect_word(20, 32'h0000A5C3, 1'b0);
    expect_word(36, 32'h00001234, 1'b1);
    play(ws_q.size());
    compare_words("msb");

    // LSB-first: wire bits reversed, same words expected.
    start_scn(1'b1, 5'd15, 3'd0, 1'b1, 1'b1);
    new_stream(1'b1, 4, 1'b0);
    add_half(1'b0, 32'hA5C3, 32'h0, 1, 16, 16, 1'b1);
    add_half(1'b1, 32'h1234, 32'h0, 1, 16, 16, 1'b1);
    add_trail(1'b0);
    expect_word(20, 32'h0000A5C3, 1'b0);
    expect_word(36, 32'h00001234, 1'b1);
    play(ws_q.size());
    compare_words("lsb");

    // Two bytes per half-frame.
    start_scn(1'b1, 5'd7, 3'd1, 1'b0, 1'b1);
    new_stream(1'b1, 4, 1'b0);
    add_half(1'b0, 32'h11, 32'h22, 2, 8, 16, 1'b0);
    add_half(1'b1, 32'h33, 32'h44, 2, 8, 16, 1'b0);
    add_trail(1'b0);
    expect_word(12, 32'h11, 1'b0);
    expect_word(20, 32'h22, 1'b0);
    expect_word(28, 32'h33, 1'b1);
    expect_word(36, 32'h44, 1'b1);
    play(ws_q.size());
    compare_words("multi");

    // Backpressure: third word (0x33 at cycle 28) must be dropped.
    start_scn(1'b1, 5'd7, 3'd1, 1'b0, 1'b0);
    new_stream(1'b1, 4, 1'b0);
    add_half(1'b0, 32'h11, 32'h22, 2, 8, 16, 1'b0);
    add_half(1'b1, 32'h33, 32'h44, 2, 8, 16, 1'b0);
    play(31);
    chk("bp_valid", 64'(data_valid), 64'd1);
    chk("bp_head", 64'(data), 64'h11);
    chk("bp_head_ch", 64'(ch), 64'd0);
    chk("bp_ovf", 64'(overflow), 64'd1);
    data_ready = 1'b1;
    cycle(1'b1, 1'b0);
    data_ready = 1'b0;
    chk("bp_second", 64'(data), 64'h22);
    chk("bp_second_ch", 64'(ch), 64'd0);
    chk("bp_second_valid", 64'(data_valid), 64'd1);
    chk("bp_ovf_sticky", 64'(overflow), 64'd1);
    cfg_en = 1'b0;
    cycle(1'b1, 1'b0);
    chk("bp_clr_ovf", 64'(overflow), 64'd0);
    chk("bp_clr_valid", 64'(data_valid), 64'd0);

    // Early WS edge after 10 bits: partial discarded, 0xBEEF on ch1.
    start_scn(1'b1, 5'd15, 3'd0, 1'b0, 1'b1);
    new_stream(1'b1, 4, 1'b0);
    add_half(1'b0, 32'hFFFF, 32'h0, 1, 16, 10, 1'b0);
    add_half(1'b1, 32'hBEEF, 32'h0, 1, 16, 16, 1'b0);
    add_trail(1'b0);
    expect_word(30, 32'h0000BEEF, 1'b1);
    play(ws_q.size());
    compare_words("early");

    // Reset mid-word with a held word in the buffer.
    start_scn(1'b0, 5'd15, 3'd0, 1'b0, 1'b0);
    new_stream(1'b0, 4, 1'b0);
    add_half(1'b1, 32'h1234, 32'h0, 1, 16, 16, 1'b0);
    add_half(1'b0, 32'hA5C3, 32'h0, 1, 16, 16, 1'b0);
    play(26);
    chk("pre_rst_data", 64'(data), 64'h1234);
    chk("pre_rst_ch", 64'(ch), 64'd1);
    chk("pre_rst_valid", 64'(data_valid), 64'd1);
    @(negedge clk);
    rstn = 1'b0;
    #1;
    chk("mid_rst_data", 64'(data), 64'd0);
    chk("mid_rst_ch", 64'(ch), 64'd0);
    chk("mid_rst_valid", 64'(data_valid), 64'd0);
    chk("mid_rst_ovf", 64'(overflow), 64'd0);
    ws = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rstn       = 1'b1;
    data_ready = 1'b1;
    obs_w.delete();
    obs_c.delete();
    exp_w.delete();
    exp_c.delete();
    new_stream(1'b0, 40, 1'b1);
    add_half(1'b1, 32'h5A5A, 32'h0, 1, 16, 16, 1'b0);
    add_trail(1'b0);
    expect_word(56, 32'h00005A5A, 1'b1);
    play(ws_q.size());
    compare_words("post_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
